// File: rtl/rgb_to_ycbcr_pkg.sv
// Shared colour-conversion constants, the 4:2:2 pair-phase type and small
// fixed-point helpers used by the RGB -> BT.601 YCbCr pipeline.
package rgb_to_ycbcr_pkg;

  localparam int YCC_KR_Y  = 66;
  localparam int YCC_KG_Y  = 129;
  localparam int YCC_KB_Y  = 25;
  localparam int YCC_K_38  = 38;
  localparam int YCC_K_74  = 74;
  localparam int YCC_K_112 = 112;
  localparam int YCC_K_94  = 94;
  localparam int YCC_K_18  = 18;
  localparam int YCC_OFS_Y = 4096;
  localparam int YCC_OFS_C = 32768;

  localparam logic [7:0] Y_MIN = 8'd16;
  localparam logic [7:0] Y_MAX = 8'd235;
  localparam logic [7:0] C_MIN = 8'd16;
  localparam logic [7:0] C_MAX = 8'd240;

  localparam int SYNC_DEPTH = 5;

  typedef enum logic {
    PHASE_EVEN = 1'b0,
    PHASE_ODD  = 1'b1
  } phase_t;

  // Unsigned 8b sample times a small constant coefficient, 18b result.
  function automatic logic [17:0] mul_k(input logic [7:0] a, input int k);
    return 18'(a) * 18'(k);
  endfunction

  function automatic logic [7:0] clamp_u8(input logic [17:0] v,
                                          input logic [7:0]  lo,
                                          input logic [7:0]  hi);
    logic [7:0] res;
    if (v < 18'(lo))
      res = lo;
    else if (v > 18'(hi))
      res = hi;
    else
      res = v[7:0];
    return res;
  endfunction

  // Round-half-up average of two 8b values.
  function automatic logic [7:0] avg_u8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

endpackage

// File: rtl/rgb_to_ycbcr_chroma_422_pack.sv
// 4:2:2 chroma packer: tracks pair phase of the pixel in S4, averages Cb of a
// pixel pair on the even pixel and Cr on the odd one, and registers o_c.
module chroma_422_pack
  import rgb_to_ycbcr_pkg::*;
#(
  parameter int CHROMA_422 = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s3_cb,
  input  logic       s3_en,
  input  logic [7:0] s4_cb,
  input  logic [7:0] s4_cr,
  input  logic       s4_en,
  output logic [7:0] c_8b
);

  phase_t     phase_q, phase_d;
  logic [7:0] cr_hold_q, cr_hold_d;
  logic [7:0] c_q, c_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PHASE_EVEN;
      cr_hold_q <= 8'd0;
      c_q       <= 8'd0;
    end else begin
      phase_q   <= phase_d;
      cr_hold_q <= cr_hold_d;
      c_q       <= c_d;
    end
  end

  // The S3 pixel is odd only when it directly follows an even valid pixel in S4.
  always_comb begin
    phase_d   = PHASE_EVEN;
    cr_hold_d = cr_hold_q;
    c_d       = s4_cb;
    if (s3_en && s4_en && (phase_q == PHASE_EVEN))
      phase_d = PHASE_ODD;
    if ((CHROMA_422 != 0) && s4_en) begin
      if (phase_q == PHASE_EVEN) begin
        cr_hold_d = s4_cr;
        c_d       = s3_en ? avg_u8(s4_cb, s3_cb) : s4_cb;
      end else begin
        c_d = avg_u8(cr_hold_q, s4_cr);
      end
    end
  end

  assign c_8b = c_q;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// RGB888 -> BT.601 studio-range YCbCr, 1 pixel/clk, 5-cycle latency on every
// output, with sync/enable delayed alongside and optional 4:2:2 chroma.
module rgb_to_ycbcr
  import rgb_to_ycbcr_pkg::*;
#(
  parameter int CHROMA_422 = 1,
  parameter int ROUND      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_r_8b,
  input  logic [7:0] i_g_8b,
  input  logic [7:0] i_b_8b,
  input  logic       i_h_sync,
  input  logic       i_v_sync,
  input  logic       i_data_en,
  output logic [7:0] o_y_8b,
  output logic [7:0] o_cb_8b,
  output logic [7:0] o_cr_8b,
  output logic [7:0] o_c_8b,
  output logic       o_h_sync,
  output logic       o_v_sync,
  output logic       o_data_en
);

  localparam logic [17:0] RND_VAL = (ROUND != 0) ? 18'd128 : 18'd0;

  logic [17:0] prod_y_r, prod_y_g, prod_y_b;
  logic [17:0] prod_cb_r, prod_cb_g, prod_cb_b;
  logic [17:0] prod_cr_r, prod_cr_g, prod_cr_b;

  logic [17:0] y_sum, cb_pos, cb_neg, cr_pos, cr_neg;

  logic [7:0] y_s3, cb_s3, cr_s3;
  logic [7:0] y_s4, cb_s4, cr_s4;
  logic [7:0] y_q, cb_q, cr_q;

  logic [SYNC_DEPTH-1:0] hs_sr, vs_sr, de_sr;

  // S1: coefficient products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_y_r  <= 18'd0;
      prod_y_g  <= 18'd0;
      prod_y_b  <= 18'd0;
      prod_cb_r <= 18'd0;
      prod_cb_g <= 18'd0;
      prod_cb_b <= 18'd0;
      prod_cr_r <= 18'd0;
      prod_cr_g <= 18'd0;
      prod_cr_b <= 18'd0;
    end else begin
      prod_y_r  <= mul_k(i_r_8b, YCC_KR_Y);
      prod_y_g  <= mul_k(i_g_8b, YCC_KG_Y);
      prod_y_b  <= mul_k(i_b_8b, YCC_KB_Y);
      prod_cb_r <= mul_k(i_r_8b, YCC_K_38);
      prod_cb_g <= mul_k(i_g_8b, YCC_K_74);
      prod_cb_b <= mul_k(i_b_8b, YCC_K_112);
      prod_cr_r <= mul_k(i_r_8b, YCC_K_112);
      prod_cr_g <= mul_k(i_g_8b, YCC_K_94);
      prod_cr_b <= mul_k(i_b_8b, YCC_K_18);
    end
  end

  // S2: positive and negative sums kept apart so every value stays unsigned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sum  <= 18'd0;
      cb_pos <= 18'd0;
      cb_neg <= 18'd0;
      cr_pos <= 18'd0;
      cr_neg <= 18'd0;
    end else begin
      y_sum  <= prod_y_r + prod_y_g + prod_y_b + 18'(YCC_OFS_Y) + RND_VAL;
      cb_pos <= prod_cb_b + 18'(YCC_OFS_C) + RND_VAL;
      cb_neg <= prod_cb_r + prod_cb_g;
      cr_pos <= prod_cr_r + 18'(YCC_OFS_C) + RND_VAL;
      cr_neg <= prod_cr_g + prod_cr_b;
    end
  end

  // S3: subtract, scale down and clamp to the studio range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s3  <= 8'd0;
      cb_s3 <= 8'd0;
      cr_s3 <= 8'd0;
    end else begin
      y_s3  <= clamp_u8(y_sum >> 8, Y_MIN, Y_MAX);
      cb_s3 <= clamp_u8((cb_pos - cb_neg) >> 8, C_MIN, C_MAX);
      cr_s3 <= clamp_u8((cr_pos - cr_neg) >> 8, C_MIN, C_MAX);
    end
  end

  // S4 hold stage and output registers; S4 lets the packer see the next pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s4  <= 8'd0;
      cb_s4 <= 8'd0;
      cr_s4 <= 8'd0;
      y_q   <= 8'd0;
      cb_q  <= 8'd0;
      cr_q  <= 8'd0;
    end else begin
      y_s4  <= y_s3;
      cb_s4 <= cb_s3;
      cr_s4 <= cr_s3;
      y_q   <= y_s4;
      cb_q  <= cb_s4;
      cr_q  <= cr_s4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[SYNC_DEPTH-2:0], i_h_sync};
      vs_sr <= {vs_sr[SYNC_DEPTH-2:0], i_v_sync};
      de_sr <= {de_sr[SYNC_DEPTH-2:0], i_data_en};
    end
  end

  chroma_422_pack #(
    .CHROMA_422 (CHROMA_422)
  ) u_chroma_422_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .s3_cb (cb_s3),
    .s3_en (de_sr[2]),
    .s4_cb (cb_s4),
    .s4_cr (cr_s4),
    .s4_en (de_sr[3]),
    .c_8b  (o_c_8b)
  );

  assign o_y_8b    = y_q;
  assign o_cb_8b   = cb_q;
  assign o_cr_8b   = cr_q;
  assign o_h_sync  = hs_sr[SYNC_DEPTH-1];
  assign o_v_sync  = vs_sr[SYNC_DEPTH-1];
  assign o_data_en = de_sr[SYNC_DEPTH-1];

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Randomised bench for rgb_to_ycbcr: every output is checked 5 clk after its
// input against a per-pixel arithmetic model and run-position 4:2:2 pairing.
module tb_rgb_to_ycbcr;

  localparam int N   = 4096;
  localparam int RND = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_r_8b, i_g_8b, i_b_8b;
  logic       i_h_sync, i_v_sync, i_data_en;
  logic [7:0] o_y_8b, o_cb_8b, o_cr_8b, o_c_8b;
  logic       o_h_sync, o_v_sync, o_data_en;

  always #5 clk = ~clk;

  rgb_to_ycbcr #(
    .CHROMA_422 (1),
    .ROUND      (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_r_8b    (i_r_8b),
    .i_g_8b    (i_g_8b),
    .i_b_8b    (i_b_8b),
    .i_h_sync  (i_h_sync),
    .i_v_sync  (i_v_sync),
    .i_data_en (i_data_en),
    .o_y_8b    (o_y_8b),
    .o_cb_8b   (o_cb_8b),
    .o_cr_8b   (o_cr_8b),
    .o_c_8b    (o_c_8b),
    .o_h_sync  (o_h_sync),
    .o_v_sync  (o_v_sync),
    .o_data_en (o_data_en)
  );

  // Input history, one entry per clock; in-flight entries are voided on reset.
  int hR [N];
  int hG [N];
  int hB [N];
  bit hEn[N];
  bit hH [N];
  bit hV [N];
  int dY [N];
  int dCb[N];
  int dCr[N];
  int dC [N];

  int t        = 0;
  int checks   = 0;
  int failures = 0;
  bit inReset  = 1'b1;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int refY(int r, int g, int b);
    return clampi((66*r + 129*g + 25*b + 4096 + RND) / 256, 16, 235);
  endfunction

  function automatic int refCb(int r, int g, int b);
    return clampi(((112*b + 32768 + RND) - (38*r + 74*g)) / 256, 16, 240);
  endfunction

  function automatic int refCr(int r, int g, int b);
    return clampi(((112*r + 32768 + RND) - (94*g + 18*b)) / 256, 16, 240);
  endfunction

  function automatic int avgi(int a, int b);
    return (a + b + 1) / 2;
  endfunction

  // Number of valid pixels immediately preceding entry k in the same run.
  function automatic int runPos(int k);
    int p = 0;
    while ((k - 1 - p >= 0) && hEn[k-1-p])
      p++;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic checkCycle();
    int k, cb, cbN, crP, cr, expC;
    k = t - 5;
    if (k < 0)
      return;
    checkOutput("h_sync",  int'(o_h_sync),  int'(hH[k]));
    checkOutput("v_sync",  int'(o_v_sync),  int'(hV[k]));
    checkOutput("data_en", int'(o_data_en), int'(hEn[k]));
    if (hEn[k]) begin
      cb = refCb(hR[k], hG[k], hB[k]);
      cr = refCr(hR[k], hG[k], hB[k]);
      if (runPos(k) % 2 == 0) begin
        cbN  = refCb(hR[k+1], hG[k+1], hB[k+1]);
        expC = hEn[k+1] ? avgi(cb, cbN) : cb;
      end else begin
        crP  = refCr(hR[k-1], hG[k-1], hB[k-1]);
        expC = avgi(crP, cr);
      end
      checkOutput("y",  int'(o_y_8b),  refY(hR[k], hG[k], hB[k]));
      checkOutput("cb", int'(o_cb_8b), cb);
      checkOutput("cr", int'(o_cr_8b), cr);
      checkOutput("c422", int'(o_c_8b), expC);
      if (dY[k]  >= 0) checkOutput("dir_y",  int'(o_y_8b),  dY[k]);
      if (dCb[k] >= 0) checkOutput("dir_cb", int'(o_cb_8b), dCb[k]);
      if (dCr[k] >= 0) checkOutput("dir_cr", int'(o_cr_8b), dCr[k]);
      if (dC[k]  >= 0) checkOutput("dir_c",  int'(o_c_8b),  dC[k]);
    end
  endtask

  task automatic recordEntry(input int r, input int g, input int b, input bit h,
                             input bit v, input bit en, input int dy, input int dcb,
                             input int dcr, input int dc);
    hR[t]  = r;
    hG[t]  = g;
    hB[t]  = b;
    hEn[t] = inReset ? 1'b0 : en;
    hH[t]  = inReset ? 1'b0 : h;
    hV[t]  = inReset ? 1'b0 : v;
    dY[t]  = dy;
    dCb[t] = dcb;
    dCr[t] = dcr;
    dC[t]  = dc;
    t++;
  endtask

  task automatic applyStimulus(input int r, input int g, input int b, input bit h,
                               input bit v, input bit en, input int dy = -1,
                               input int dcb = -1, input int dcr = -1, input int dc = -1);
    @(negedge clk);
    checkCycle();
    i_r_8b    = 8'(r);
    i_g_8b    = 8'(g);
    i_b_8b    = 8'(b);
    i_h_sync  = h;
    i_v_sync  = v;
    i_data_en = en;
    recordEntry(r, g, b, h, v, en, dy, dcb, dcr, dc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_y"},  int'(o_y_8b),  0);
    checkOutput({tag, "_cb"}, int'(o_cb_8b), 0);
    checkOutput({tag, "_cr"}, int'(o_cr_8b), 0);
    checkOutput({tag, "_c"},  int'(o_c_8b),  0);
    checkOutput({tag, "_hs"}, int'(o_h_sync),  0);
    checkOutput({tag, "_vs"}, int'(o_v_sync),  0);
    checkOutput({tag, "_de"}, int'(o_data_en), 0);
  endtask

  task automatic assertReset();
    @(negedge clk);
    checkCycle();
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    for (int i = t - 4; i < t; i++) begin
      if (i >= 0) begin
        hEn[i] = 1'b0;
        hH[i]  = 1'b0;
        hV[i]  = 1'b0;
      end
    end
    inReset = 1'b1;
    recordEntry(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    checkCycle();
    rst_n     = 1'b1;
    inReset   = 1'b0;
    i_data_en = 1'b0;
    i_h_sync  = 1'b0;
    i_v_sync  = 1'b0;
    recordEntry(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1);
  endtask

  task automatic randomRun(input int n, input int enPct);
    for (int i = 0; i < n; i++)
      applyStimulus(int'($urandom_range(255)), int'($urandom_range(255)),
                    int'($urandom_range(255)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), ($urandom_range(99) < enPct));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", t);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    i_r_8b    = 8'd0;
    i_g_8b    = 8'd0;
    i_b_8b    = 8'd0;
    i_h_sync  = 1'b0;
    i_v_sync  = 1'b0;
    i_data_en = 1'b0;
    #1;
    checkAllZero("rst_init");
    idle(3);
    releaseReset();
    idle(2);

    $display("[TB] isolated colour pixels");
    applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 16, 128, 128, 128);
    idle(1);
    applyStimulus(255, 255, 255, 1'b0, 1'b0, 1'b1, 235, 128, 128, 128);
    idle(1);
    applyStimulus(255, 0, 0, 1'b0, 1'b0, 1'b1, 82, 90, 240, 90);
    idle(1);
    applyStimulus(0, 0, 255, 1'b0, 1'b0, 1'b1, 41, 240, 110, 240);
    idle(2);

    $display("[TB] red/blue pair");
    applyStimulus(255, 0, 0, 1'b1, 1'b0, 1'b1, 82, -1, -1, 165);
    applyStimulus(0, 0, 255, 1'b0, 1'b1, 1'b1, 41, -1, -1, 175);
    idle(2);

    $display("[TB] three-pixel run then new run");
    applyStimulus(255, 0, 0, 1'b0, 1'b0, 1'b1, 82, -1, -1, 165);
    applyStimulus(0, 0, 255, 1'b0, 1'b0, 1'b1, 41, -1, -1, 175);
    applyStimulus(255, 0, 0, 1'b0, 1'b0, 1'b1, 82, -1, -1, 90);
    idle(1);
    applyStimulus(0, 0, 255, 1'b0, 1'b0, 1'b1, 41, -1, -1, 165);
    applyStimulus(255, 0, 0, 1'b0, 1'b0, 1'b1, 82, -1, -1, 175);
    idle(2);

    $display("[TB] random traffic");
    randomRun(600, 80);
    randomRun(200, 50);

    $display("[TB] reset in the middle of a run");
    randomRun(7, 100);
    assertReset();
    idle(2);
    releaseReset();
    applyStimulus(0, 0, 255, 1'b0, 1'b0, 1'b1, 41, -1, -1, 165);
    applyStimulus(255, 0, 0, 1'b0, 1'b0, 1'b1, 82, -1, -1, 175);
    randomRun(300, 85);
    idle(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
